wave_analyzer: RTL and testbench
================================

# wave_analyzer

Measures a 16-bit signed sample stream, such as the generator's `wave_digital` output, and reports per-period statistics: period in samples, peak-to-peak amplitude and DC offset. It sits on the receive end of the audio test path. Edge detection uses hysteresis, so ripple or added noise around zero does not cause false triggers. Results update once per detected period with a one-cycle valid pulse. A no-signal flag is raised when no edge arrives within the counter range.

## Interface
- `DATA_W`, default 16: sample width, two's complement.
- `CNT_W`, default 24: period counter width; timeout is at `2^CNT_W-1` samples.
- `HYST`, default 256: hysteresis threshold magnitude, unsigned, less than `2^(DATA_W-1)`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_en` in 1: sample strobe; `sample_in` is accepted only in cycles where it is high.
- `sample_in` in `DATA_W`: signed sample.
- `clear` in 1: synchronous restart of the measurement.
- `period_out` out `CNT_W`: samples per period.
- `pk_pk_out` out `DATA_W+1`: max − min, unsigned.
- `offset_out` out `DATA_W`: (max + min) >>> 1, signed.
- `meas_valid` out 1: one-cycle pulse when the outputs update.
- `no_signal` out 1: timeout flag, sticky.

## Operation
- Hysteresis levels:
  - LOW condition: `sample_in <= -HYST`.
  - HIGH condition: `sample_in >= +HYST`.
  - A rising edge is an accepted HIGH sample while in a LO-armed state.
- FSM states:
  - IDLE → SEEK_LOW unconditionally on the next cycle.
  - SEEK_LOW → SEEK_RISE on a LOW sample.
  - SEEK_RISE → MEAS_HI on an edge (first edge: start the measurement; nothing is published).
  - MEAS_HI → MEAS_LO on a LOW sample.
  - MEAS_LO → MEAS_HI on an edge, which publishes results.
- Sample counter `cnt`:
  - Set to 1 on an edge sample.
  - Incremented on every other accepted sample in SEEK_* and MEAS_* states.
- Min/max: loaded with the edge sample, then updated with every accepted sample.
- Publish on an edge in MEAS_LO:
  - `period_out` = `cnt` value before the reload.
  - `pk_pk_out` = max − min, computed at `DATA_W+1` bits with no overflow.
  - `offset_out` = (max + min) computed at `DATA_W+1` bits, arithmetic shift right by 1, truncated to `DATA_W`.
  - The edge sample belongs to the new period and is excluded from the published min/max.
- Timeout: when `cnt` reaches `2^CNT_W-1` without an edge:
  - `no_signal` ← 1, go to SEEK_LOW, `cnt` ← 0.
  - `no_signal` clears on the next `meas_valid`.
- `sample_en` low: state, counter and min/max hold.
- `clear`: all outputs ← 0, FSM ← IDLE. `clear` has priority over a simultaneous `sample_en`. The period in progress is discarded.
- Reset: same effect as `clear`. Every output is 0 and the FSM is in IDLE.

## Timing
- Results are registered. `meas_valid` and all outputs change in the cycle after the edge sample is accepted.
- Outputs hold until the next `meas_valid`, `clear` or reset.
- `meas_valid` never lasts more than one cycle. It is separated from the next pulse by at least 2 accepted samples (the minimum period).
- `no_signal` rises one cycle after the sample that saturates `cnt`.

## Configuration
- `WAVE_ANALYZER_AVG_EN` defined: results are accumulated over 4 consecutive periods, and `meas_valid` pulses once per 4 periods.
  - `period_out` = floor(sum / 4); the sum is held at `CNT_W+2` bits.
  - `pk_pk_out` and `offset_out` are taken over the combined 4-period min/max.
  - The group counter resets on `clear`, reset and timeout.
- Not defined: results are published every period.

## Structure
- Package `wave_meas_pkg` holds:
  - the FSM state enum `wa_state_t` (IDLE, SEEK_LOW, SEEK_RISE, MEAS_HI, MEAS_LO);
  - default constants for `DATA_W`, `CNT_W` and `HYST`.
- Sub-module `min_max_tracker`:
  - inputs: `load`, `en`, `din`;
  - outputs: registered `min` and `max`;
  - instantiated once, or twice when `WAVE_ANALYZER_AVG_EN` is defined, for the group extremes.

## Test plan
- Square wave at ±8000, 8 samples high and 8 low, `sample_en`=1 every cycle → first `meas_valid` after the second rising edge with `period_out`=16, `pk_pk_out`=16000, `offset_out`=0; then repeats every 16 cycles.
- Asymmetric square at +8000/−2000, 10 high and 6 low → `period_out`=16, `pk_pk_out`=10000, `offset_out`=3000.
- Slow wave with ±100 ripple superimposed on each zero crossing → exactly one `meas_valid` per true period, and `period_out` equals the true period.
- Bench with `CNT_W`=8, constant input 50 → `no_signal`=1 after 255 accepted samples and `meas_valid` is never asserted. Applying the 16-sample square afterwards → `no_signal` clears on the first `meas_valid`.
- `sample_en` high only every 4th cycle with the 16-sample square → `period_out`=16, and `meas_valid` spacing is 64 cycles.
- `clear` asserted mid-period in MEAS_LO → all outputs 0 the next cycle and no `meas_valid` for the aborted period. Reset asserted asynchronously mid-period gives the same result.

Source files
------------

// File: rtl/wave_meas_pkg.sv
// Shared types and default sizing for the wave analyzer.
package wave_meas_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 24;
  localparam int HYST_DEF   = 256;

  typedef enum logic [2:0] {
    IDLE,
    SEEK_LOW,
    SEEK_RISE,
    MEAS_HI,
    MEAS_LO
  } wa_state_t;

endpackage

// File: rtl/min_max_tracker.sv
// Signed running min/max. Load seeds both extremes; en folds in a new sample.
module min_max_tracker #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min <= '0;
      max <= '0;
    end else if (load) begin
      min <= din;
      max <= din;
    end else if (en) begin
      if ($signed(din) < $signed(min)) min <= din;
      if ($signed(din) > $signed(max)) max <= din;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Per-period period / peak-to-peak / DC-offset meter with hysteresis edge detection.
// WAVE_ANALYZER_AVG_EN: publish once per 4 periods with averaged period and group extremes.
module wave_analyzer
  import wave_meas_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HYST   = HYST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              clear,
  output logic [CNT_W-1:0]  period_out,
  output logic [DATA_W:0]   pk_pk_out,
  output logic [DATA_W-1:0] offset_out,
  output logic              meas_valid,
  output logic              no_signal
);

  localparam logic signed [DATA_W:0] HI_TH = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] LO_TH = -HI_TH;
  // One below saturation: the sample that would take cnt to all-ones times out.
  localparam logic [CNT_W-1:0] CNT_TOP = {{(CNT_W-1){1'b1}}, 1'b0};

  wa_state_t              state, nxt;
  logic [CNT_W-1:0]       cnt;
  logic signed [DATA_W:0] s_ext;
  logic                   accept, is_low, is_high;
  logic                   rise, publish, timeout;
  logic                   pub_now;
  logic [CNT_W-1:0]       per_val;
  logic [DATA_W-1:0]      p_min, p_max, src_min, src_max;
  logic signed [DATA_W:0] mx_e, mn_e, mm_sum;
  logic [DATA_W:0]        mm_diff;

  assign s_ext   = $signed({sample_in[DATA_W-1], sample_in});
  assign accept  = sample_en & ~clear;
  assign is_low  = s_ext <= LO_TH;
  assign is_high = s_ext >= HI_TH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clear)              nxt = IDLE;
    else if (state == IDLE) nxt = SEEK_LOW;
    else if (accept) begin
      if (timeout) nxt = SEEK_LOW;
      else begin
        case (state)
          SEEK_LOW:  if (is_low)  nxt = SEEK_RISE;
          SEEK_RISE: if (is_high) nxt = MEAS_HI;
          MEAS_HI:   if (is_low)  nxt = MEAS_LO;
          MEAS_LO:   if (is_high) nxt = MEAS_HI;
          default:                nxt = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rise    = 1'b0;
    publish = 1'b0;
    timeout = 1'b0;
    if (accept) begin
      case (state)
        SEEK_RISE: rise = is_high;
        MEAS_LO: begin
          rise    = is_high;
          publish = is_high;
        end
        default: ;
      endcase
      if (state != IDLE && !rise && cnt == CNT_TOP) timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (accept && state != IDLE) begin
      if (rise)         cnt <= CNT_W'(1);
      else if (timeout) cnt <= '0;
      else              cnt <= cnt + 1'b1;
    end
  end

  // Loaded on the edge sample, so at publish time it still excludes that sample.
  min_max_tracker #(.DATA_W(DATA_W)) u_per (
    .clk(clk), .rst_n(rst_n), .load(rise), .en(accept),
    .din(sample_in), .min(p_min), .max(p_max)
  );

`ifdef WAVE_ANALYZER_AVG_EN
  logic [1:0]       grp;
  logic [CNT_W+1:0] psum, psum_nxt;
  logic             first_rise;
  logic [DATA_W-1:0] g_min, g_max;

  assign first_rise = rise & (state == SEEK_RISE);
  assign psum_nxt   = psum + {2'b00, cnt};
  assign pub_now    = publish & (grp == 2'd3);
  assign per_val    = psum_nxt[CNT_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp  <= '0;
      psum <= '0;
    end else if (clear || timeout || first_rise || pub_now) begin
      grp  <= '0;
      psum <= '0;
    end else if (publish) begin
      grp  <= grp + 1'b1;
      psum <= psum_nxt;
    end
  end

  min_max_tracker #(.DATA_W(DATA_W)) u_grp (
    .clk(clk), .rst_n(rst_n), .load(first_rise | pub_now), .en(accept),
    .din(sample_in), .min(g_min), .max(g_max)
  );

  assign src_min = g_min;
  assign src_max = g_max;
`else
  assign pub_now = publish;
  assign per_val = cnt;
  assign src_min = p_min;
  assign src_max = p_max;
`endif

  assign mx_e    = $signed({src_max[DATA_W-1], src_max});
  assign mn_e    = $signed({src_min[DATA_W-1], src_min});
  assign mm_diff = mx_e - mn_e;
  assign mm_sum  = mx_e + mn_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      period_out <= '0;
      pk_pk_out  <= '0;
      offset_out <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (timeout) no_signal <= 1'b1;
      if (pub_now) begin
        period_out <= per_val;
        pk_pk_out  <= mm_diff;
        offset_out <= mm_sum[DATA_W:1];
        meas_valid <= 1'b1;
        no_signal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_analyzer.sv
// Table-driven scoreboard bench for wave_analyzer (default build, CNT_W=8).
module tb_wave_analyzer;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef struct {
    int hi; int lo; int hi_len; int per; int div;
    bit rip; bit trig; int nper;
    int e_per; int e_pk; int e_off;
  } vec_t;

  typedef struct { int per; int pk; int off; } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [CW-1:0] period_out;
  logic [DW:0]   pk_pk_out;
  logic [DW-1:0] offset_out;
  logic          meas_valid;
  logic          no_signal;

  int   total = 0, bad = 0, cyc = 0, nvalid = 0, last_vcyc = -1, exp_gap = 0;
  bit   prev_mv = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  vec_t vt[8];

  wave_analyzer #(.DATA_W(DW), .CNT_W(CW), .HYST(256)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sample_in(sample_in),
    .clear(clear), .period_out(period_out), .pk_pk_out(pk_pk_out),
    .offset_out(offset_out), .meas_valid(meas_valid), .no_signal(no_signal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic step(input logic en, input int val, input logic clr);
    @(negedge clk);
    sample_en = en;
    sample_in = 16'(val);
    clear     = clr;
  endtask

  function automatic int wval(input vec_t v, input int j);
    if (v.rip) begin
      if (j < 4 || (j >= 30 && j < 36)) return (j % 2) ? 100 : -100;
      return (j < 30) ? v.hi : v.lo;
    end
    return (j < v.hi_len) ? v.hi : v.lo;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_pk"}, pk_pk_out, 0);
    chk({tag, "_off"}, offset_out, 0);
    chk({tag, "_valid"}, meas_valid, 0);
    chk({tag, "_nosig"}, no_signal, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit do_clr);
    int ej, n0;
    if (do_clr) begin
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
    end
    ej        = v.rip ? 4 : 0;
    exp_gap   = (v.div > 1) ? v.per * v.div : 0;
    last_vcyc = -1;
    n0        = nvalid;
    for (int k = 0; k < v.nper; k++)
      for (int j = 0; j < v.per; j++) begin
        if (v.trig && j == ej && k >= 2) q.push_back('{v.e_per, v.e_pk, v.e_off});
        step(1'b1, wval(v, j), 1'b0);
        for (int d = 1; d < v.div; d++)
          step(1'b0, int'($urandom_range(65535)) - 32768, 1'b0);
      end
    repeat (3) step(1'b0, 0, 1'b0);
    chk("pending", q.size(), 0);
    chk("n_valid", nvalid - n0, v.trig ? v.nper - 2 : 0);
    exp_gap = 0;
  endtask

  // Clear, then drive until (stop_k, stop_j), leaving the FSM mid-period.
  task automatic partial(input vec_t v, input int stop_k, input int stop_j);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    for (int k = 0; k <= stop_k; k++)
      for (int j = 0; j < v.per; j++) begin
        if (k == stop_k && j == stop_j) return;
        if (j == 0 && k >= 2) q.push_back('{v.e_per, v.e_pk, v.e_off});
        step(1'b1, wval(v, j), 1'b0);
      end
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      chk("valid_width", prev_mv, 0);
      chk("nosig_on_valid", no_signal, 0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid act=1 req=0");
      end else begin
        mon_e = q.pop_front();
        chk("period", period_out, mon_e.per);
        chk("pk_pk", pk_pk_out, mon_e.pk);
        chk("offset", $signed(offset_out), mon_e.off);
      end
      if (exp_gap != 0 && last_vcyc >= 0) chk("valid_gap", cyc - last_vcyc, exp_gap);
      last_vcyc = cyc;
      nvalid++;
    end
    prev_mv = meas_valid;
  end

  initial begin
    int n1;
    vt[0] = '{8000,   -8000,  8, 16, 1, 1'b0, 1'b1, 5, 16, 16000,  0};
    vt[1] = '{8000,   -2000, 10, 16, 1, 1'b0, 1'b1, 5, 16, 10000,  3000};
    vt[2] = '{3000,   -3000,  0, 64, 1, 1'b1, 1'b1, 4, 64,  6000,  0};
    vt[3] = '{8000,   -8000,  8, 16, 4, 1'b0, 1'b1, 4, 16, 16000,  0};
    vt[4] = '{256,    -256,   3,  5, 1, 1'b0, 1'b1, 5,  5,   512,  0};
    vt[5] = '{255,    -255,   3,  5, 1, 1'b0, 1'b0, 6,  0,     0,  0};
    vt[6] = '{32767, -32768,  4,  8, 1, 1'b0, 1'b1, 4,  8, 65535, -1};
    vt[7] = '{1000,   -1000,  1,  2, 1, 1'b0, 1'b1, 6,  2,  2000,  0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], 1'b1);

    // Timeout on a constant input that never crosses the thresholds.
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    n1 = nvalid;
    for (int i = 0; i < 254; i++) step(1'b1, 50, 1'b0);
    step(1'b1, 50, 1'b0);
    chk("nosig_before_sat", no_signal, 0);
    step(1'b0, 0, 1'b0);
    chk("nosig_after_sat", no_signal, 1);
    chk("valid_during_timeout", nvalid - n1, 0);
    run_vec(vt[0], 1'b0);
    chk("nosig_after_recover", no_signal, 0);

    // Clear in MEAS_LO, with a would-be edge sample on the same cycle.
    partial(vt[1], 2, 12);
    chk("pre_clear_period", period_out, 16);
    chk("pre_clear_offset", offset_out, 3000);
    n1 = nvalid;
    step(1'b1, 8000, 1'b1);
    step(1'b0, 0, 1'b0);
    check_zero("clear");
    for (int j = 0; j < 20; j++) step(1'b1, wval(vt[1], j % 16), 1'b0);
    step(1'b0, 0, 1'b0);
    chk("clear_no_valid", nvalid - n1, 0);
    chk("clear_hold_pk", pk_pk_out, 0);

    // Asynchronous reset mid-period.
    partial(vt[1], 2, 12);
    chk("pre_rst_pk", pk_pk_out, 10000);
    n1 = nvalid;
    #2;
    rst_n = 1'b0;
    sample_en = 1'b1;
    sample_in = 16'd8000;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    sample_en = 1'b0;
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) step(1'b1, wval(vt[1], j % 16), 1'b0);
    step(1'b0, 0, 1'b0);
    chk("rst_no_valid", nvalid - n1, 0);
    chk("rst_hold_period", period_out, 0);
    chk("rst_pending", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
